scoreboard_multi: RTL and testbench

// - Parametrised multi-player score counter for the Nim game top level. Keeps one

---
 rtl/scoreboard_multi.sv | 138 +++++++++++++
 tb/tb_scoreboard_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_multi.sv
// Multi-player BCD-style score counter with rising-edge step detection,
// wrap/saturate limits and an optional winner latch that freezes play.
module scoreboard_multi #(
  parameter int PLAYERS   = 2,
  parameter int DIGITS    = 2,
  parameter int RADIX     = 10,
  parameter int WRAP      = 1,
  parameter int WIN_SCORE = 0
) (
  input  logic                        clk,
  input  logic                        resetScore,
  input  logic [PLAYERS-1:0]          inc,
  input  logic [PLAYERS-1:0]          dec,
  output logic [PLAYERS*DIGITS*4-1:0] score,
  output logic [PLAYERS-1:0]          ovf,
  output logic [PLAYERS-1:0]          unf,
  output logic                        game_over,
  output logic [2:0]                  winner
);

  localparam int SW = DIGITS * 4;
  localparam logic [3:0] DMAX = 4'(RADIX - 1);
  localparam logic [SW-1:0] MAX_VEC = {DIGITS{DMAX}};

  function automatic logic [SW-1:0] win_digits();
    logic [SW-1:0] r;
    int unsigned   v;
    r = '0;
    v = WIN_SCORE;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(v % RADIX);
      v           = v / RADIX;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] WIN_VEC = win_digits();

  logic [PLAYERS-1:0]          inc_q, inc_d, dec_q, dec_d;
  logic [PLAYERS-1:0]          ovf_q, ovf_d, unf_q, unf_d;
  logic [PLAYERS*SW-1:0]       score_q, score_d;
  logic                        game_over_q, game_over_d;
  logic [2:0]                  winner_q, winner_d;
  logic [PLAYERS-1:0]          rise_inc, rise_dec, win_hit;
  logic [SW-1:0]               cur, nxt;
  logic                        carry;

  always_comb begin
    inc_d       = inc;
    dec_d       = dec;
    score_d     = score_q;
    ovf_d       = '0;
    unf_d       = '0;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    win_hit     = '0;
    cur         = '0;
    nxt         = '0;
    carry       = 1'b0;
    rise_inc    = inc & ~inc_q;
    rise_dec    = dec & ~dec_q;
    if (!game_over_q) begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        cur = score_q[p*SW +: SW];
        nxt = cur;
        if (rise_inc[p]) begin
          if (cur == MAX_VEC) begin
            ovf_d[p] = 1'b1;
            if (WRAP != 0) nxt = '0;
          end else begin
            carry = 1'b1;
            for (int unsigned d = 0; d < DIGITS; d++) begin
              if (carry) begin
                if (cur[d*4 +: 4] == DMAX) begin
                  nxt[d*4 +: 4] = '0;
                end else begin
                  nxt[d*4 +: 4] = cur[d*4 +: 4] + 4'd1;
                  carry         = 1'b0;
                end
              end
            end
            win_hit[p] = (WIN_SCORE != 0) && (nxt == WIN_VEC);
          end
        end else if (rise_dec[p]) begin
          if (cur == '0) begin
            unf_d[p] = 1'b1;
            if (WRAP != 0) nxt = MAX_VEC;
          end else begin
            carry = 1'b1;
            for (int unsigned d = 0; d < DIGITS; d++) begin
              if (carry) begin
                if (cur[d*4 +: 4] == 4'd0) begin
                  nxt[d*4 +: 4] = DMAX;
                end else begin
                  nxt[d*4 +: 4] = cur[d*4 +: 4] - 4'd1;
                  carry         = 1'b0;
                end
              end
            end
          end
        end
        score_d[p*SW +: SW] = nxt;
      end
      // Scan downwards so the lowest-index winner is the last one written.
      for (int unsigned p = PLAYERS; p > 0; p--) begin
        if (win_hit[p-1]) begin
          game_over_d = 1'b1;
          winner_d    = 3'(p - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    inc_q <= inc_d;
    dec_q <= dec_d;
    if (resetScore) begin
      score_q     <= '0;
      ovf_q       <= '0;
      unf_q       <= '0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else begin
      score_q     <= score_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign score     = score_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_scoreboard_multi.sv
// Bench for scoreboard_multi: four configurations share one stimulus stream;
// an integer model feeds a queue of expected outputs checked after each edge.
module tb_scoreboard_multi;

  logic       clk = 1'b0;
  logic       resetScore = 1'b0;
  logic [1:0] inc = '0;
  logic [1:0] dec = '0;

  logic [15:0] score_w [4];
  logic [1:0]  ovf_w   [4];
  logic [1:0]  unf_w   [4];
  logic        go_w    [4];
  logic [2:0]  win_w   [4];

  always #5 clk = ~clk;

  scoreboard_multi #(.PLAYERS(2), .DIGITS(2), .RADIX(10), .WRAP(1), .WIN_SCORE(0)) u_a (
    .clk(clk), .resetScore(resetScore), .inc(inc), .dec(dec), .score(score_w[0]),
    .ovf(ovf_w[0]), .unf(unf_w[0]), .game_over(go_w[0]), .winner(win_w[0]));
  scoreboard_multi #(.PLAYERS(2), .DIGITS(2), .RADIX(10), .WRAP(0), .WIN_SCORE(0)) u_b (
    .clk(clk), .resetScore(resetScore), .inc(inc), .dec(dec), .score(score_w[1]),
    .ovf(ovf_w[1]), .unf(unf_w[1]), .game_over(go_w[1]), .winner(win_w[1]));
  scoreboard_multi #(.PLAYERS(2), .DIGITS(2), .RADIX(6), .WRAP(1), .WIN_SCORE(0)) u_c (
    .clk(clk), .resetScore(resetScore), .inc(inc), .dec(dec), .score(score_w[2]),
    .ovf(ovf_w[2]), .unf(unf_w[2]), .game_over(go_w[2]), .winner(win_w[2]));
  scoreboard_multi #(.PLAYERS(2), .DIGITS(2), .RADIX(10), .WRAP(1), .WIN_SCORE(5)) u_d (
    .clk(clk), .resetScore(resetScore), .inc(inc), .dec(dec), .score(score_w[3]),
    .ovf(ovf_w[3]), .unf(unf_w[3]), .game_over(go_w[3]), .winner(win_w[3]));

  int m_r  [4] = '{10, 10, 6, 10};
  int m_wr [4] = '{1, 0, 1, 1};
  int m_wn [4] = '{0, 0, 0, 5};

  int         m_s   [4][2];
  logic [1:0] m_pi  [4];
  logic [1:0] m_pd  [4];
  logic [1:0] m_ovf [4];
  logic [1:0] m_unf [4];
  logic       m_go  [4];
  int         m_win [4];

  typedef struct {
    int          k;
    logic [15:0] score;
    logic [1:0]  ovf;
    logic [1:0]  unf;
    logic        go;
    logic [2:0]  win;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [1:0]  inc;
    logic [1:0]  dec;
    logic [15:0] exp_score;
    logic [1:0]  exp_ovf;
    logic [1:0]  exp_unf;
  } vec_t;
  vec_t tbl [12];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] enc(int k, int s0, int s1);
    logic [15:0] r;
    r[3:0]   = 4'(s0 % m_r[k]);
    r[7:4]   = 4'((s0 / m_r[k]) % m_r[k]);
    r[11:8]  = 4'(s1 % m_r[k]);
    r[15:12] = 4'((s1 / m_r[k]) % m_r[k]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic [1:0] i, input logic [1:0] d);
    int maxv;
    logic hit;
    int hp;
    logic [1:0] ri, rd;
    maxv = m_r[k] * m_r[k] - 1;
    hit = 1'b0;
    hp = 0;
    ri = i & ~m_pi[k];
    rd = d & ~m_pd[k];
    m_pi[k] = i;
    m_pd[k] = d;
    m_ovf[k] = '0;
    m_unf[k] = '0;
    if (rst) begin
      m_s[k][0] = 0;
      m_s[k][1] = 0;
      m_go[k] = 1'b0;
      m_win[k] = 0;
    end else if (!m_go[k]) begin
      for (int p = 0; p < 2; p++) begin
        if (ri[p]) begin
          if (m_s[k][p] == maxv) begin
            m_ovf[k][p] = 1'b1;
            if (m_wr[k] != 0) m_s[k][p] = 0;
          end else begin
            m_s[k][p]++;
            if (m_wn[k] != 0 && m_s[k][p] == m_wn[k] && !hit) begin
              hit = 1'b1;
              hp = p;
            end
          end
        end else if (rd[p]) begin
          if (m_s[k][p] == 0) begin
            m_unf[k][p] = 1'b1;
            if (m_wr[k] != 0) m_s[k][p] = maxv;
          end else begin
            m_s[k][p]--;
          end
        end
      end
      if (hit) begin
        m_go[k] = 1'b1;
        m_win[k] = hp;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] i, input logic [1:0] d);
    exp_t e;
    resetScore = rst;
    inc = i;
    dec = d;
    for (int k = 0; k < 4; k++) begin
      model_step(k, rst, i, d);
      e.k = k;
      e.score = enc(k, m_s[k][0], m_s[k][1]);
      e.ovf = m_ovf[k];
      e.unf = m_unf[k];
      e.go = m_go[k];
      e.win = 3'(m_win[k]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      e = sbq.pop_front();
      chk($sformatf("k%0d score", e.k), 32'(score_w[e.k]), 32'(e.score));
      chk($sformatf("k%0d ovf", e.k), 32'(ovf_w[e.k]), 32'(e.ovf));
      chk($sformatf("k%0d unf", e.k), 32'(unf_w[e.k]), 32'(e.unf));
      chk($sformatf("k%0d game_over", e.k), 32'(go_w[e.k]), 32'(e.go));
      chk($sformatf("k%0d winner", e.k), 32'(win_w[e.k]), 32'(e.win));
    end
  endtask

  task automatic pulse(input logic [1:0] i, input logic [1:0] d);
    drive(1'b0, i, d);
    drive(1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    tbl[0]  = '{2'b01, 2'b00, 16'h0001, 2'b00, 2'b00};
    tbl[1]  = '{2'b00, 2'b00, 16'h0001, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 2'b00, 16'h0102, 2'b00, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 16'h0102, 2'b00, 2'b00};
    tbl[4]  = '{2'b00, 2'b01, 16'h0101, 2'b00, 2'b00};
    tbl[5]  = '{2'b01, 2'b01, 16'h0102, 2'b00, 2'b00};
    tbl[6]  = '{2'b00, 2'b00, 16'h0102, 2'b00, 2'b00};
    tbl[7]  = '{2'b01, 2'b01, 16'h0103, 2'b00, 2'b00};
    tbl[8]  = '{2'b00, 2'b10, 16'h0003, 2'b00, 2'b00};
    tbl[9]  = '{2'b00, 2'b00, 16'h0003, 2'b00, 2'b00};
    tbl[10] = '{2'b00, 2'b10, 16'h9903, 2'b00, 2'b10};
    tbl[11] = '{2'b00, 2'b00, 16'h9903, 2'b00, 2'b00};

    drive(1'b1, 2'b00, 2'b00);
    chk("reset score", 32'(score_w[0]), 32'h0);
    chk("reset game_over", 32'(go_w[3]), 32'h0);

    for (int n = 0; n < 12; n++) begin
      drive(1'b0, tbl[n].inc, tbl[n].dec);
      chk($sformatf("tbl%0d score", n), 32'(score_w[0]), 32'(tbl[n].exp_score));
      chk($sformatf("tbl%0d ovf", n), 32'(ovf_w[0]), 32'(tbl[n].exp_ovf));
      chk($sformatf("tbl%0d unf", n), 32'(unf_w[0]), 32'(tbl[n].exp_unf));
    end

    drive(1'b1, 2'b00, 2'b00);
    for (int n = 0; n < 12; n++) pulse(2'b01, 2'b00);
    chk("twelve score", 32'(score_w[0]), 32'h0012);
    chk("twelve win freeze", 32'(score_w[3]), 32'h0005);

    drive(1'b1, 2'b00, 2'b00);
    for (int n = 0; n < 20; n++) drive(1'b0, 2'b10, 2'b00);
    drive(1'b0, 2'b00, 2'b00);
    chk("hold once", 32'(score_w[0]), 32'h0100);

    drive(1'b1, 2'b00, 2'b00);
    drive(1'b0, 2'b00, 2'b01);
    chk("wrap dec A", 32'({score_w[0], unf_w[0]}), 32'({16'h0099, 2'b01}));
    chk("sat dec B", 32'({score_w[1], unf_w[1]}), 32'({16'h0000, 2'b01}));
    chk("wrap dec C", 32'({score_w[2], unf_w[2]}), 32'({16'h0055, 2'b01}));
    drive(1'b0, 2'b00, 2'b00);
    chk("unf one cycle", 32'(unf_w[0]), 32'h0);
    drive(1'b0, 2'b01, 2'b00);
    chk("wrap inc A", 32'({score_w[0], ovf_w[0]}), 32'({16'h0000, 2'b01}));
    chk("inc B", 32'({score_w[1], ovf_w[1]}), 32'({16'h0001, 2'b00}));
    chk("wrap inc C", 32'({score_w[2], ovf_w[2]}), 32'({16'h0000, 2'b01}));
    drive(1'b0, 2'b00, 2'b00);

    drive(1'b1, 2'b00, 2'b00);
    for (int n = 1; n <= 99; n++) begin
      pulse(2'b01, 2'b00);
      if (n == 6)  chk("radix6 six", 32'(score_w[2]), 32'h0010);
      if (n == 35) chk("radix6 max", 32'(score_w[2]), 32'h0055);
    end
    chk("count 99 A", 32'(score_w[0]), 32'h0099);
    chk("count 99 B", 32'(score_w[1]), 32'h0099);
    drive(1'b0, 2'b01, 2'b00);
    chk("ovf wrap A", 32'({score_w[0], ovf_w[0]}), 32'({16'h0000, 2'b01}));
    chk("ovf sat B", 32'({score_w[1], ovf_w[1]}), 32'({16'h0099, 2'b01}));
    drive(1'b0, 2'b00, 2'b00);

    drive(1'b1, 2'b00, 2'b00);
    for (int n = 0; n < 5; n++) pulse(2'b10, 2'b00);
    chk("win p1", 32'({go_w[3], win_w[3], score_w[3]}), 32'({1'b1, 3'd1, 16'h0500}));
    pulse(2'b11, 2'b00);
    pulse(2'b00, 2'b11);
    chk("frozen", 32'({go_w[3], win_w[3], score_w[3], ovf_w[3], unf_w[3]}),
        32'({1'b1, 3'd1, 16'h0500, 2'b00, 2'b00}));
    drive(1'b1, 2'b00, 2'b00);
    for (int n = 0; n < 5; n++) pulse(2'b11, 2'b00);
    chk("win lowest", 32'({go_w[3], win_w[3], score_w[3]}), 32'({1'b1, 3'd0, 16'h0505}));

    drive(1'b0, 2'b01, 2'b00);
    drive(1'b1, 2'b01, 2'b00);
    chk("reset held inc", 32'({score_w[0], go_w[3], score_w[3]}), 32'h0);
    for (int n = 0; n < 3; n++) drive(1'b0, 2'b01, 2'b00);
    chk("no inc after reset", 32'(score_w[0]), 32'h0);
    drive(1'b0, 2'b00, 2'b00);
    drive(1'b0, 2'b01, 2'b00);
    chk("inc after re-rise", 32'(score_w[0]), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
